// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
//   Shared types and defaults for the instruction fetch slice.
//   - ADDR_WIDTH / DATA_WIDTH : fetch address and instruction word widths
//   - IFETCH_FIFO_DEPTH       : default instruction buffer depth (credit limit)
//   - IFETCH_MAX_OUTSTANDING  : default cap on granted-but-unanswered requests
//   - ifetch_state_e          : fetch FSM states (RUN / DRAIN)
//   - ifetch_entry_t          : buffered instruction with its PC
// ----------------------------------------------------------------------------
package core_pkg;

    localparam int ADDR_WIDTH             = 32;
    localparam int DATA_WIDTH             = 32;
    localparam int IFETCH_FIFO_DEPTH      = 2;
    localparam int IFETCH_MAX_OUTSTANDING = 2;

    typedef enum logic {
        IFETCH_RUN   = 1'b0,
        IFETCH_DRAIN = 1'b1
    } ifetch_state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0] pc;
    } ifetch_entry_t;

endpackage

// File: rtl/ifetch_if.sv
// ----------------------------------------------------------------------------
// ifetch_if
//   Instruction-memory request bus (req/gnt/rvalid).
//   - req    : fetch request              (master -> slave)
//   - addr   : fetch address              (master -> slave)
//   - gnt    : request accepted           (slave -> master)
//   - rvalid : response valid, in order   (slave -> master)
//   - rdata  : instruction word           (slave -> master)
//   modport master : fetch unit side
//   modport slave  : memory side
// ----------------------------------------------------------------------------
interface ifetch_if;
    import core_pkg::*;

    logic                  req;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/ifetch_fifo.sv
// ----------------------------------------------------------------------------
// ifetch_fifo
//   Generic synchronous FIFO with async active-low reset and sync clear.
//   Parameters: Width (entry bits), Depth (entries, power of 2, >= 2).
//   Ports:
//   - clk_i, rstn_i : clock, async active-low reset
//   - clr_i         : drop all entries (wins over push/pop)
//   - push_i/wdata_i: write; ignored when full unless popping the same cycle
//   - pop_i         : read advance; ignored when empty
//   - rdata_o       : head entry, forced to 0 while empty
//   - empty_o/full_o/count_o : occupancy
// ----------------------------------------------------------------------------
module ifetch_fifo #(
    parameter int Width = 32,
    parameter int Depth = 2
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           rdata_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);
    localparam int PtrW = $clog2(Depth);
    localparam int CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_q, rd_q;
    logic [CntW-1:0]  cnt_q;
    logic             push_ok, pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CntW'(Depth));
    assign count_o = cnt_q;
    assign rdata_o = empty_o ? '0 : mem[rd_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_i);

    // Power-of-2 depth: pointers wrap by natural overflow.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + PtrOne;
            if (pop_ok)  rd_q <= rd_q + PtrOne;
            cnt_q <= cnt_q + CntW'(push_ok) - CntW'(pop_ok);
        end
    end

    // Storage is data-path only; occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (push_ok && !clr_i) mem[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/ifetch.sv
// ----------------------------------------------------------------------------
// ifetch
//   Instruction fetch unit. Issues instruction-memory requests at pc_i,
//   pulses pc_adv_o back to the PC updater on each accepted request, buffers
//   responses with their PCs and delivers them to decode over valid/ready.
//   A redirect (flush_i) drops buffered data and discards in-flight responses.
//   Parameters: FifoDepth (buffer entries / credit limit), MaxOutstanding.
//   Ports:
//   - clk_i, rstn_i        : clock, async active-low reset
//   - pc_i, pc_adv_o       : PC updater interface
//   - flush_i              : redirect; new PC appears on pc_i next cycle
//   - imem                 : ifetch_if.master request bus
//   - instr_valid_o/instr_o/instr_pc_o/instr_ready_i : decode handshake
//   - perf_fetch_o, perf_stall_o : delivered / starved counters
//   Build option: IFETCH_PERF_EN enables the perf counters; otherwise they
//   read 0 and no counter state exists.
// ----------------------------------------------------------------------------
module ifetch
    import core_pkg::*;
#(
    parameter int FifoDepth      = IFETCH_FIFO_DEPTH,
    parameter int MaxOutstanding = IFETCH_MAX_OUTSTANDING
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    output logic                  pc_adv_o,
    input  logic                  flush_i,
    ifetch_if.master              imem,
    output logic                  instr_valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_pc_o,
    input  logic                  instr_ready_i,
    output logic [31:0]           perf_fetch_o,
    output logic [31:0]           perf_stall_o
);
    localparam int OutW = $clog2(MaxOutstanding + 1);
    localparam int CntW = $clog2(FifoDepth + 1);
    localparam logic [OutW-1:0] OutOne = OutW'(1);

    ifetch_state_e   state_q, state_d;
    logic [OutW-1:0] out_q, out_d;
    logic [OutW-1:0] disc_q, disc_d;

    logic            credit_ok, accept, rsp_keep;

    ifetch_entry_t   ibuf_wdata, ibuf_head;
    logic            ibuf_empty, ibuf_full;
    logic [CntW-1:0] ibuf_cnt;

    logic [ADDR_WIDTH-1:0] pend_head;
    logic                  pend_empty, pend_full;
    logic [CntW-1:0]       pend_cnt;

    // Buffered plus in-flight must never exceed the buffer, so every
    // response has a slot waiting for it.
    assign credit_ok = (int'(out_q) < MaxOutstanding)
                    && ((int'(out_q) + int'(ibuf_cnt)) < FifoDepth);

    // Reset is folded in so the bus reads idle while rstn_i is low.
    assign imem.req  = rstn_i && !flush_i && (state_q == IFETCH_RUN) && credit_ok;
    assign imem.addr = rstn_i ? pc_i : '0;
    assign accept    = imem.req && imem.gnt;
    assign pc_adv_o  = accept;

    // Responses are kept only when no stale ones remain to be discarded.
    assign rsp_keep  = imem.rvalid && (disc_q == '0);

    assign ibuf_wdata = '{instr: imem.rdata, pc: pend_head};

    ifetch_fifo #(.Width($bits(ifetch_entry_t)), .Depth(FifoDepth)) u_ibuf (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .clr_i   (flush_i),
        .push_i  (rsp_keep),
        .wdata_i (ibuf_wdata),
        .pop_i   (instr_ready_i),
        .rdata_o (ibuf_head),
        .empty_o (ibuf_empty),
        .full_o  (ibuf_full),
        .count_o (ibuf_cnt)
    );

    ifetch_fifo #(.Width(ADDR_WIDTH), .Depth(FifoDepth)) u_pend (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .clr_i   (flush_i),
        .push_i  (accept),
        .wdata_i (pc_i),
        .pop_i   (rsp_keep),
        .rdata_o (pend_head),
        .empty_o (pend_empty),
        .full_o  (pend_full),
        .count_o (pend_cnt)
    );

    assign instr_valid_o = !ibuf_empty;
    assign instr_o       = ibuf_head.instr;
    assign instr_pc_o    = ibuf_head.pc;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IFETCH_RUN;
            out_q   <= '0;
            disc_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            disc_q  <= disc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        disc_d  = disc_q;
        if (flush_i) begin
            // Everything still in flight is stale; a response landing this
            // cycle is already accounted for.
            disc_d  = out_q - OutW'(imem.rvalid);
            out_d   = disc_d;
            state_d = (disc_d != '0) ? IFETCH_DRAIN : IFETCH_RUN;
        end else begin
            unique case (state_q)
                IFETCH_RUN: begin
                    out_d = out_q + OutW'(accept) - OutW'(imem.rvalid);
                end
                IFETCH_DRAIN: begin
                    if (imem.rvalid) begin
                        disc_d = disc_q - OutOne;
                        out_d  = out_q - OutOne;
                        if (disc_q == OutOne) state_d = IFETCH_RUN;
                    end
                end
                default: state_d = IFETCH_RUN;
            endcase
        end
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_stall_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (instr_valid_o && instr_ready_i)  perf_fetch_q <= perf_fetch_q + 32'd1;
            if (instr_ready_i && !instr_valid_o) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetch_o = perf_fetch_q;
    assign perf_stall_o = perf_stall_q;
`else
    assign perf_fetch_o = '0;
    assign perf_stall_o = '0;
`endif

    // Protocol and bookkeeping invariants.
    a_rvalid_owed: assert property (@(posedge clk_i) disable iff (!rstn_i)
        imem.rvalid |-> (out_q != '0));
    a_pend_head: assert property (@(posedge clk_i) disable iff (!rstn_i)
        rsp_keep |-> !pend_empty);
    a_pend_room: assert property (@(posedge clk_i) disable iff (!rstn_i)
        accept |-> !pend_full);
    a_ibuf_room: assert property (@(posedge clk_i) disable iff (!rstn_i)
        rsp_keep |-> (!ibuf_full || instr_ready_i));
    a_pend_track: assert property (@(posedge clk_i) disable iff (!rstn_i)
        (state_q == IFETCH_RUN) |-> (int'(pend_cnt) == int'(out_q)));

endmodule

// File: tb/tb_ifetch.sv
// ----------------------------------------------------------------------------
// tb_ifetch
//   Directed bench for ifetch. The environment holds a PC updater (+4 on
//   pc_adv_o, load on flush) and an in-order memory whose responses follow the
//   grant by one cycle when resp_en is set. Deliveries to decode are logged
//   and compared against hand-derived PC/instruction sequences.
// ----------------------------------------------------------------------------
module tb_ifetch;
    import core_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic flush = 1'b0;
    logic ready = 1'b0;
    logic resp_en = 1'b1;
    logic pc_adv, instr_valid;
    logic [ADDR_WIDTH-1:0] pc_reg;
    logic [ADDR_WIDTH-1:0] pc_start = '0;
    logic [ADDR_WIDTH-1:0] redirect_pc = '0;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic [DATA_WIDTH-1:0] instr;
    logic [31:0] perf_fetch, perf_stall;

    int n_chk = 0;
    int n_err = 0;

    logic [ADDR_WIDTH-1:0] mem_addr [1024];
    logic [ADDR_WIDTH-1:0] log_pc   [1024];
    logic [DATA_WIDTH-1:0] log_in   [1024];
    int wr_ptr = 0, rd_ptr = 0, acc_cnt = 0, log_cnt = 0;

`ifdef IFETCH_PERF_EN
    localparam logic [31:0] EXP_FETCH8 = 32'd8;
    localparam logic [31:0] EXP_FETCH  = 32'd10;
    localparam logic [31:0] EXP_STALL  = 32'd3;
`else
    localparam logic [31:0] EXP_FETCH8 = 32'd0;
    localparam logic [31:0] EXP_FETCH  = 32'd0;
    localparam logic [31:0] EXP_STALL  = 32'd0;
`endif

    ifetch_if imem();

    ifetch dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .pc_i          (pc_reg),
        .pc_adv_o      (pc_adv),
        .flush_i       (flush),
        .imem          (imem),
        .instr_valid_o (instr_valid),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_ready_i (ready),
        .perf_fetch_o  (perf_fetch),
        .perf_stall_o  (perf_stall)
    );

    always #5 clk = ~clk;

    // PC updater.
    always @(posedge clk or negedge rstn) begin
        if (!rstn)       pc_reg <= pc_start;
        else if (flush)  pc_reg <= redirect_pc;
        else if (pc_adv) pc_reg <= pc_reg + 32'd4;
    end

    // Record accepted requests and delivered instructions.
    always @(posedge clk) begin
        if (rstn) begin
            if (imem.req && imem.gnt) begin
                mem_addr[wr_ptr % 1024] <= imem.addr;
                wr_ptr  <= wr_ptr + 1;
                acc_cnt <= acc_cnt + 1;
            end
            if (instr_valid && ready) begin
                log_pc[log_cnt % 1024] <= instr_pc;
                log_in[log_cnt % 1024] <= instr;
                log_cnt <= log_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; drive this cycle's memory response away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (resp_en && (rd_ptr != wr_ptr)) begin
            imem.rvalid = 1'b1;
            imem.rdata  = mem_addr[rd_ptr % 1024] ^ 32'hDEAD_0000;
            rd_ptr++;
        end else begin
            imem.rvalid = 1'b0;
            imem.rdata  = '0;
        end
        #1;
    endtask

    task automatic do_reset(input logic [31:0] spc, input logic rdy);
        pc_start    = spc;
        ready       = rdy;
        flush       = 1'b0;
        resp_en     = 1'b1;
        imem.gnt    = 1'b0;
        imem.rvalid = 1'b0;
        imem.rdata  = '0;
        rstn        = 1'b0;
        rd_ptr      = wr_ptr;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic run_drain(input int n);
        repeat (n) tick();
        imem.gnt = 1'b0;
        ready    = 1'b1;
        repeat (8) tick();
    endtask

    task automatic check_log(input string tag, input int lbase, input int abase,
                             input int skip, input logic [31:0] pc0);
        int n;
        logic [31:0] epc;
        n = log_cnt - lbase;
        chk($sformatf("%s_count", tag), n, acc_cnt - abase - skip);
        for (int i = 0; i < n; i++) begin
            epc = pc0 + 32'(4 * i);
            chk($sformatf("%s_pc%0d", tag, i), log_pc[(lbase + i) % 1024], epc);
            chk($sformatf("%s_in%0d", tag, i), log_in[(lbase + i) % 1024], epc ^ 32'hDEAD_0000);
        end
    endtask

    initial begin
        int lb, ab;
        imem.gnt    = 1'b0;
        imem.rvalid = 1'b0;
        imem.rdata  = '0;

        // Reset state, with grant and a nonzero PC presented.
        pc_start = 32'h80;
        imem.gnt = 1'b1;
        ready    = 1'b1;
        tick();
        chk("rst_req",   imem.req, 0);
        chk("rst_addr",  imem.addr, 0);
        chk("rst_adv",   pc_adv, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_ipc",   instr_pc, 0);
        chk("rst_pfetch", perf_fetch, 0);
        chk("rst_pstall", perf_stall, 0);

        // 1: streaming fetch from 0x0, response one cycle after grant.
        do_reset(32'h0, 1'b1);
        lb = log_cnt; ab = acc_cnt;
        imem.gnt = 1'b1;
        #1;
        chk("t1_c0_req",  imem.req, 1);
        chk("t1_c0_addr", imem.addr, 32'h0);
        chk("t1_c0_adv",  pc_adv, 1);
        chk("t1_c0_vld",  instr_valid, 0);
        tick();
        chk("t1_c1_addr", imem.addr, 32'h4);
        chk("t1_c1_req",  imem.req, 1);
        chk("t1_c1_vld",  instr_valid, 0);
        tick();
        chk("t1_c2_vld",  instr_valid, 1);
        chk("t1_c2_ipc",  instr_pc, 32'h0);
        chk("t1_c2_in",   instr, 32'hDEAD_0000);
        chk("t1_c2_req",  imem.req, 0);
        tick();
        chk("t1_c3_vld",  instr_valid, 1);
        chk("t1_c3_ipc",  instr_pc, 32'h4);
        chk("t1_c3_req",  imem.req, 1);
        chk("t1_c3_addr", imem.addr, 32'h8);
        run_drain(10);
        chk("t1_min3", (log_cnt - lb) >= 3, 1);
        check_log("t1", lb, ab, 0, 32'h0);

        // 2: decode stalled -> credit stops after FifoDepth grants.
        do_reset(32'h0, 1'b0);
        lb = log_cnt; ab = acc_cnt;
        imem.gnt = 1'b1;
        #1;
        repeat (3) tick();
        chk("t2_c3_req", imem.req, 0);
        repeat (3) tick();
        chk("t2_c6_req",  imem.req, 0);
        chk("t2_granted", acc_cnt - ab, 2);
        chk("t2_vld",     instr_valid, 1);
        chk("t2_ipc",     instr_pc, 32'h0);
        ready = 1'b1;
        tick();
        chk("t2_resume_req",  imem.req, 1);
        chk("t2_resume_addr", imem.addr, 32'h8);
        run_drain(12);
        chk("t2_more", (acc_cnt - ab) > 2, 1);
        check_log("t2", lb, ab, 0, 32'h0);

        // 3: flush with two outstanding, redirect to 0x100.
        do_reset(32'h0, 1'b1);
        lb = log_cnt; ab = acc_cnt;
        resp_en  = 1'b0;
        imem.gnt = 1'b1;
        #1;
        tick();
        tick();
        chk("t3_c2_req", imem.req, 0);
        flush       = 1'b1;
        redirect_pc = 32'h100;
        resp_en     = 1'b1;
        #1;
        chk("t3_f_req", imem.req, 0);
        chk("t3_f_adv", pc_adv, 0);
        tick();
        flush = 1'b0;
        #1;
        chk("t3_d1_req", imem.req, 0);
        chk("t3_d1_vld", instr_valid, 0);
        tick();
        chk("t3_d2_req", imem.req, 0);
        chk("t3_d2_vld", instr_valid, 0);
        tick();
        chk("t3_run_req",  imem.req, 1);
        chk("t3_run_addr", imem.addr, 32'h100);
        run_drain(10);
        check_log("t3", lb, ab, 2, 32'h100);

        // 4: flush in the same cycle as rvalid and gnt.
        do_reset(32'h0, 1'b1);
        lb = log_cnt; ab = acc_cnt;
        resp_en  = 1'b0;
        imem.gnt = 1'b1;
        #1;
        tick();
        resp_en = 1'b1;
        tick();
        chk("t4_rv", imem.rvalid, 1);
        flush       = 1'b1;
        redirect_pc = 32'h200;
        #1;
        chk("t4_f_req", imem.req, 0);
        chk("t4_f_adv", pc_adv, 0);
        chk("t4_f_vld", instr_valid, 0);
        tick();
        flush = 1'b0;
        #1;
        chk("t4_d1_req", imem.req, 0);
        chk("t4_d1_vld", instr_valid, 0);
        tick();
        chk("t4_run_req",  imem.req, 1);
        chk("t4_run_addr", imem.addr, 32'h200);
        chk("t4_run_vld",  instr_valid, 0);
        run_drain(10);
        check_log("t4", lb, ab, 2, 32'h200);

        // 5: asynchronous reset with a full buffer.
        do_reset(32'h0, 1'b0);
        imem.gnt = 1'b1;
        #1;
        repeat (3) tick();
        chk("t5_pre_vld", instr_valid, 1);
        chk("t5_pre_ipc", instr_pc, 32'h0);
        pc_start = 32'h40;
        rstn     = 1'b0;
        #1;
        chk("t5_req",   imem.req, 0);
        chk("t5_addr",  imem.addr, 0);
        chk("t5_adv",   pc_adv, 0);
        chk("t5_vld",   instr_valid, 0);
        chk("t5_instr", instr, 0);
        chk("t5_ipc",   instr_pc, 0);
        do_reset(32'h40, 1'b1);
        lb = log_cnt; ab = acc_cnt;
        imem.gnt = 1'b1;
        #1;
        chk("t5_re_req",  imem.req, 1);
        chk("t5_re_addr", imem.addr, 32'h40);
        run_drain(10);
        check_log("t5", lb, ab, 0, 32'h40);

        // 6: performance counters: 10 pops, 3 starved-ready cycles.
        do_reset(32'h0, 1'b0);
        imem.gnt = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            repeat (4) tick();
            ready = 1'b1;
            tick();
            ready = 1'b0;
        end
        chk("t6_fetch8", perf_fetch, EXP_FETCH8);
        chk("t6_stall0", perf_stall, 0);
        repeat (4) tick();
        imem.gnt = 1'b0;
        ready    = 1'b1;
        repeat (5) tick();
        ready = 1'b0;
        tick();
        chk("t6_fetch", perf_fetch, EXP_FETCH);
        chk("t6_stall", perf_stall, EXP_STALL);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
